// File: rtl/dct_frame_sched.sv
`default_nettype none
//============================================================================
// dct_frame_sched : walks a frame of 8x8 blocks, feeds dct2d one block at a
// time and streams its coefficients. Define ZIGZAG_EN for zigzag read order.
// Revision: 1.0
//============================================================================
module dct_frame_sched #(
   parameter int FADDR_W = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [FADDR_W-1:0] base_addr,
   input  logic [FADDR_W-1:0] stride,
   input  logic [7:0]         width_blks,
   input  logic [7:0]         height_blks,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               frd,
   output logic [FADDR_W-1:0] faddr,
   input  logic [7:0]         fq,
   output logic               bwren,
   output logic [5:0]         baddr,
   output logic [7:0]         bdata,
   output logic               dct_en,
   input  logic               dct_rdy,
   output logic [5:0]         caddr,
   input  logic [15:0]        cq,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [15:0]        out_data,
   output logic               out_last
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      KICK      = 3'd2,
      WAIT_BUSY = 3'd3,
      WAIT_DONE = 3'd4,
      DRAIN     = 3'd5,
      NEXT      = 3'd6
   } state_t;

   state_t             r_state;
   logic [FADDR_W-1:0] r_stride;
   logic [FADDR_W-1:0] r_row_addr;   // pixel (by*8, 0)
   logic [FADDR_W-1:0] r_blk_addr;   // pixel (by*8, bx*8)
   logic [FADDR_W-1:0] r_line_addr;  // pixel (by*8+r, bx*8)
   logic [7:0]         r_width;
   logic [7:0]         r_height;
   logic [7:0]         r_bx;
   logic [7:0]         r_by;
   logic [6:0]         r_cnt;
   logic [1:0]         r_wb_cnt;
   logic [5:0]         r_n;

   logic [FADDR_W-1:0] w_next_row;
   logic [FADDR_W-1:0] w_next_blk;
   logic               w_last_col;
   logic               w_last_row;

`ifdef ZIGZAG_EN
   localparam logic [5:0] ZZ_ROM [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };
   assign caddr = ZZ_ROM[r_n];
`else
   assign caddr = r_n;
`endif

   assign out_data   = cq;
   assign out_last   = out_valid && (r_n == 6'd63);
   // fq arrives the cycle after frd, which is exactly the cycle bwren is high
   assign bdata      = bwren ? fq : 8'd0;

   assign w_last_col = (r_bx + 8'd1) == r_width;
   assign w_last_row = (r_by + 8'd1) == r_height;
   assign w_next_row = r_row_addr + (r_stride << 3);
   assign w_next_blk = w_last_col ? w_next_row : r_blk_addr + FADDR_W'(8);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_stride    <= '0;
         r_row_addr  <= '0;
         r_blk_addr  <= '0;
         r_line_addr <= '0;
         r_width     <= '0;
         r_height    <= '0;
         r_bx        <= '0;
         r_by        <= '0;
         r_cnt       <= '0;
         r_wb_cnt    <= '0;
         r_n         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         frd         <= 1'b0;
         faddr       <= '0;
         bwren       <= 1'b0;
         baddr       <= '0;
         dct_en      <= 1'b0;
         out_valid   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_stride <= stride;
                  r_width  <= width_blks;
                  r_height <= height_blks;
                  err      <= 1'b0;
                  if (width_blks == 8'd0 || height_blks == 8'd0) begin
                     done <= 1'b1;
                  end else begin
                     busy        <= 1'b1;
                     r_state     <= LOAD;
                     r_bx        <= '0;
                     r_by        <= '0;
                     r_row_addr  <= base_addr;
                     r_blk_addr  <= base_addr;
                     r_line_addr <= base_addr;
                     faddr       <= base_addr;
                     frd         <= 1'b1;
                     r_cnt       <= '0;
                  end
               end
            end
            LOAD: begin
               r_cnt <= r_cnt + 7'd1;
               bwren <= frd;
               baddr <= r_cnt[5:0];
               if (r_cnt < 7'd63) begin
                  frd <= 1'b1;
                  if (r_cnt[2:0] == 3'd7) begin
                     r_line_addr <= r_line_addr + r_stride;
                     faddr       <= r_line_addr + r_stride;
                  end else begin
                     faddr <= faddr + FADDR_W'(1);
                  end
               end else begin
                  frd <= 1'b0;
               end
               if (r_cnt == 7'd64)
                  r_state <= KICK;
            end
            KICK: begin
               if (dct_rdy) begin
                  dct_en   <= 1'b1;
                  r_wb_cnt <= '0;
                  r_state  <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (!dct_rdy) begin
                  dct_en  <= 1'b0;
                  r_state <= WAIT_DONE;
               end else if (r_wb_cnt == 2'd3) begin
                  // dct2d never acknowledged: abort the whole frame
                  dct_en  <= 1'b0;
                  err     <= 1'b1;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_wb_cnt <= r_wb_cnt + 2'd1;
               end
            end
            WAIT_DONE: begin
               if (dct_rdy) begin
                  out_valid <= 1'b1;
                  r_n       <= '0;
                  r_state   <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  r_n <= r_n + 6'd1;
                  if (r_n == 6'd63) begin
                     out_valid <= 1'b0;
                     r_state   <= NEXT;
                  end
               end
            end
            NEXT: begin
               r_bx       <= w_last_col ? 8'd0 : r_bx + 8'd1;
               r_blk_addr <= w_next_blk;
               if (w_last_col) begin
                  r_by       <= r_by + 8'd1;
                  r_row_addr <= w_next_row;
               end
               if (w_last_col && w_last_row) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_line_addr <= w_next_blk;
                  faddr       <= w_next_blk;
                  frd         <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= LOAD;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dct_frame_sched.sv
`default_nettype none
//============================================================================
// tb_dct_frame_sched : directed self-checking bench for dct_frame_sched.
// Revision: 1.0
//============================================================================
module tb_dct_frame_sched;
   localparam int FADDR_W = 16;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               start;
   logic [FADDR_W-1:0] base_addr, stride;
   logic [7:0]         width_blks, height_blks;
   logic               busy, done, err, frd, bwren, dct_en, out_valid, out_last;
   logic [FADDR_W-1:0] faddr;
   logic [7:0]         fq = 8'd0;
   logic [5:0]         baddr, caddr;
   logic [7:0]         bdata;
   logic               dct_rdy = 1'b1;
   logic [15:0]        cq, out_data;
   logic               out_ready = 1'b1;

   int checks = 0;
   int errors = 0;

   dct_frame_sched #(.FADDR_W(FADDR_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .stride(stride), .width_blks(width_blks), .height_blks(height_blks),
      .busy(busy), .done(done), .err(err), .frd(frd), .faddr(faddr), .fq(fq),
      .bwren(bwren), .baddr(baddr), .bdata(bdata), .dct_en(dct_en),
      .dct_rdy(dct_rdy), .caddr(caddr), .cq(cq), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   always #5 clk = ~clk;

   // frame memory: one-cycle read latency, pixel = low address byte ^ 3C
   always @(posedge clk) fq <= frd ? (faddr[7:0] ^ 8'h3C) : 8'h00;

   // coefficient memory: block number in the top bits, address below
   logic [9:0] blk_cnt = '0;
   assign cq = {blk_cnt, caddr};

   // dct2d model and ready driver
   bit rnd_ready = 0;
   bit stuck     = 0;
   int dm_cnt    = 0;
   always @(posedge clk) begin
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stuck) begin
         dct_rdy = 1'b1;
         dm_cnt  = 0;
      end else if (dm_cnt > 0) begin
         dm_cnt--;
         if (dm_cnt == 70)     dct_rdy = 1'b0;
         else if (dm_cnt == 0) dct_rdy = 1'b1;
      end else if (dct_en && dct_rdy) begin
         dm_cnt = 72;
      end
   end

   // monitor
   int              cyc = 0;
   logic [15:0]     fa_q[$];
   int              fr_cyc[$], bw_cyc[$];
   logic [5:0]      ba_q[$];
   logic [7:0]      bd_q[$];
   logic [15:0]     od_q[$];
   logic            ol_q[$];
   int done_cnt, en_cycles, en_rise, last_cnt, stall_viol, premature, stalls;
   bit              stall_pend, prev_en;
   logic [15:0]     stall_data;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (frd) begin fa_q.push_back(faddr); fr_cyc.push_back(cyc); end
      if (bwren) begin
         ba_q.push_back(baddr); bd_q.push_back(bdata); bw_cyc.push_back(cyc);
      end
      if (dct_en) en_cycles++;
      if (dct_en && !prev_en) en_rise++;
      prev_en = dct_en;
      if (done) done_cnt++;
      if (out_valid) begin
         if (!dct_rdy) premature++;
         if (stall_pend && out_data !== stall_data) stall_viol++;
         if (out_ready) begin
            od_q.push_back(out_data);
            ol_q.push_back(out_last);
            stall_pend = 0;
            if (out_last) begin last_cnt++; blk_cnt = blk_cnt + 10'd1; end
         end else begin
            stall_pend = 1; stall_data = out_data; stalls++;
         end
      end
   end

   function automatic logic [5:0] exp_ord(int n);
`ifdef ZIGZAG_EN
      logic [5:0] zz [64] = '{
         6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
         6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
         6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
         6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
         6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
         6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
         6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
         6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};
      return zz[n];
`else
      return 6'(n);
`endif
   endfunction

   task automatic clr();
      fa_q.delete(); fr_cyc.delete(); bw_cyc.delete(); ba_q.delete();
      bd_q.delete(); od_q.delete(); ol_q.delete();
      done_cnt = 0; en_cycles = 0; en_rise = 0; last_cnt = 0;
      stall_viol = 0; premature = 0; stalls = 0; stall_pend = 0;
      blk_cnt = '0;
   endtask

   task automatic pulse_start(input logic [15:0] b, input logic [15:0] s,
                              input logic [7:0] w, input logic [7:0] h);
      @(negedge clk);
      base_addr = b; stride = s; width_blks = w; height_blks = h; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int t = 0;
      while (done_cnt == 0 && t < budget) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      checks++;
      if (done_cnt == 0) begin
         errors++; $display("FAIL wait_done: no done within %0d cycles", budget);
      end
   endtask

   task automatic check_frame(input string nm, input int nb, input int bw,
                              input logic [15:0] b, input logic [15:0] s);
      int bx, by, r, c;
      logic [15:0] ea;
      checks++;
      if (fa_q.size() != nb*64 || ba_q.size() != nb*64 || od_q.size() != nb*64) begin
         errors++;
         $display("FAIL %s_counts: frd=%0d wr=%0d out=%0d required %0d",
                  nm, fa_q.size(), ba_q.size(), od_q.size(), nb*64);
         return;
      end
      for (int i = 0; i < nb*64; i++) begin
         bx = (i/64) % bw; by = (i/64) / bw; r = (i%64) >> 3; c = i & 7;
         ea = b + 16'((by*8 + r)*s + bx*8 + c);
         checks++;
         if (fa_q[i] !== ea || ba_q[i] !== 6'(i%64) || bd_q[i] !== (ea[7:0] ^ 8'h3C)
             || bw_cyc[i] != fr_cyc[i] + 1) begin
            errors++;
            $display("FAIL %s_load[%0d]: faddr=%h baddr=%0d bdata=%h dly=%0d required %h %0d %h 1",
                     nm, i, fa_q[i], ba_q[i], bd_q[i], bw_cyc[i]-fr_cyc[i], ea, i%64, ea[7:0]^8'h3C);
         end
         checks++;
         if (od_q[i] !== {10'(i/64), exp_ord(i%64)} || ol_q[i] !== ((i%64) == 63)) begin
            errors++;
            $display("FAIL %s_out[%0d]: data=%h last=%b required %h %b",
                     nm, i, od_q[i], ol_q[i], {10'(i/64), exp_ord(i%64)}, (i%64) == 63);
         end
      end
      checks++;
      if (en_rise != nb || last_cnt != nb || done_cnt != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_ctrl: dct_en=%0d last=%0d done=%0d busy=%b required %0d %0d 1 0",
                  nm, en_rise, last_cnt, done_cnt, busy, nb, nb);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b1; base_addr = 16'h1234; stride = 16'd8;
      width_blks = 8'd1; height_blks = 8'd1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, err, frd, bwren, dct_en, out_valid, out_last} !== 8'd0) begin
         errors++;
         $display("FAIL reset_ctrl: %b required 00000000",
                  {busy, done, err, frd, bwren, dct_en, out_valid, out_last});
      end
      checks++;
      if (faddr !== 16'd0 || baddr !== 6'd0 || caddr !== 6'd0 || bdata !== 8'd0) begin
         errors++;
         $display("FAIL reset_addr: faddr=%h baddr=%h caddr=%h bdata=%h required 0",
                  faddr, baddr, caddr, bdata);
      end
      start = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_block();
      clr();
      pulse_start(16'h0000, 16'd8, 8'd1, 8'd1);
      wait_done(2000);
      check_frame("1x1", 1, 1, 16'h0000, 16'd8);
   endtask

   task automatic test_multi_block();
      clr();
      rnd_ready = 1;
      pulse_start(16'h0100, 16'd16, 8'd2, 8'd2);
      repeat (100) @(negedge clk);
      pulse_start(16'h5555, 16'd4, 8'd3, 8'd3);
      wait_done(6000);
      rnd_ready = 0;
      check_frame("2x2", 4, 2, 16'h0100, 16'd16);
      checks++;
      if (fa_q.size() == 256 && (fa_q[64] !== 16'h108 || fa_q[128] !== 16'h180
          || fa_q[192] !== 16'h188 || fa_q[200] !== 16'h198)) begin
         errors++;
         $display("FAIL 2x2_block_starts: %h %h %h %h required 0108 0180 0188 0198",
                  fa_q[64], fa_q[128], fa_q[192], fa_q[200]);
      end
      checks++;
      if (stall_viol != 0 || premature != 0) begin
         errors++;
         $display("FAIL 2x2_stall: unstable=%0d early_drain=%0d required 0 0",
                  stall_viol, premature);
      end
   endtask

   task automatic test_timeout();
      clr();
      stuck = 1;
      pulse_start(16'h0000, 16'd8, 8'd1, 8'd1);
      wait_done(1000);
      checks++;
      if (en_cycles != 4 || err !== 1'b1 || od_q.size() != 0 || done_cnt != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout: dct_en_cycles=%0d err=%b outs=%0d done=%0d busy=%b required 4 1 0 1 0",
                  en_cycles, err, od_q.size(), done_cnt, busy);
      end
      stuck = 0;
      pulse_start(16'h0000, 16'd8, 8'd0, 8'd1);
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL err_clear: err=%b required 0", err);
      end
   endtask

   task automatic test_zero_dims();
      clr();
      @(negedge clk);
      base_addr = 16'h0; stride = 16'd8; width_blks = 8'd0; height_blks = 8'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL zero_width: done=%b busy=%b required 1 0", done, busy);
      end
      @(negedge clk);
      base_addr = 16'h0; width_blks = 8'd3; height_blks = 8'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL zero_height: done=%b busy=%b required 1 0", done, busy);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (fa_q.size() != 0 || done !== 1'b0) begin
         errors++; $display("FAIL zero_reads: frd=%0d done=%b required 0 0", fa_q.size(), done);
      end
   endtask

   task automatic test_reset_mid_load();
      clr();
      pulse_start(16'h0000, 16'd8, 8'd1, 8'd1);
      repeat (10) @(negedge clk);
      checks++;
      if (frd !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL mid_load_state: frd=%b busy=%b required 1 1", frd, busy);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, frd, bwren, done} !== 4'd0 || faddr !== 16'd0 || baddr !== 6'd0) begin
         errors++;
         $display("FAIL async_reset: busy=%b frd=%b bwren=%b done=%b faddr=%h baddr=%h required 0",
                  busy, frd, bwren, done, faddr, baddr);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (100) @(negedge clk);
      checks++;
      if (done_cnt != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_no_done: done=%0d busy=%b required 0 0", done_cnt, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_multi_block();
      test_timeout();
      test_zero_dims();
      test_reset_mid_load();
      test_single_block();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dct_frame_sched.md
Name: dct_frame_sched

Overview:
- Frame-level sequencer for the dct2d core in the MPEG2 path.
- Walks a frame of 8x8 luma blocks in raster-of-blocks order.
- Per block: copies 64 pixels from frame memory into the dct2d input buffer, starts dct2d, waits for completion, then streams the 64 16-bit coefficients out on a valid/ready port.
- Strictly one block in flight.

Parameters:
- FADDR_W, 16, frame memory address width; all address arithmetic is modulo 2^FADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- base_addr  in  FADDR_W  frame address of pixel (0,0); sampled on accepted start.
- stride  in  FADDR_W  pixels per frame line; sampled on accepted start.
- width_blks  in  8  blocks per row; sampled on accepted start.
- height_blks  in  8  block rows; sampled on accepted start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at frame end.
- err  out  1  sticky dct handshake timeout; cleared by the next accepted start.
- frd  out  1  frame read strobe.
- faddr  out  FADDR_W  frame read address.
- fq  in  8  frame read data; valid exactly 1 cycle after frd.
- bwren  out  1  dct2d input buffer write enable.
- baddr  out  6  input buffer write address, row*8+col.
- bdata  out  8  input buffer write data.
- dct_en  out  1  dct2d start request.
- dct_rdy  in  1  dct2d idle/ready.
- caddr  out  6  coefficient buffer read address (combinational read).
- cq  in  16  coefficient buffer read data, same cycle as caddr.
- out_valid  out  1  coefficient stream valid.
- out_ready  in  1  coefficient stream ready.
- out_data  out  16  coefficient; equals cq.
- out_last  out  1  high with the 64th coefficient of each block.

Behaviour:
- Reset (async assert, sync release): state IDLE; block counters = 0. Outputs busy, done, err, frd, bwren, dct_en, out_valid, out_last are 0. faddr, baddr, caddr, bdata are 0.
- start is ignored unless state is IDLE.
- States are IDLE, LOAD, KICK, WAIT_BUSY, WAIT_DONE, DRAIN, NEXT.
- IDLE: on start, latch the config and clear err.
  - If width_blks==0 or height_blks==0: done pulses the next cycle, busy stays 0, no reads are issued.
  - Otherwise go to LOAD with bx=by=0.
- LOAD:
  - Issue frd for k=0..63 on consecutive cycles, with r=k>>3, c=k&7.
  - faddr = base_addr + (by*8+r)*stride + bx*8 + c, computed incrementally (no multiplier).
  - Each fq is written one cycle later: bwren=1, baddr=k, bdata=fq.
  - LOAD lasts 65 cycles, then go to KICK.
- KICK: wait for dct_rdy=1, then assert dct_en and go to WAIT_BUSY.
- WAIT_BUSY: hold dct_en=1 until dct_rdy is sampled 0, then drop dct_en and go to WAIT_DONE.
  - If dct_rdy is still 1 after 4 cycles in WAIT_BUSY: set err, drop dct_en, pulse done, go to IDLE. The frame is aborted.
- WAIT_DONE: wait for dct_rdy=1, then go to DRAIN. No timeout.
- DRAIN:
  - out_valid=1, caddr=ORDER[n], out_data=cq, out_last=(n==63).
  - n advances on out_valid&&out_ready.
  - out_data/caddr stay stable while out_ready=0.
  - After the handshake at n==63, go to NEXT.
- NEXT (1 cycle):
  - bx++. On wrap to width_blks, bx=0 and by++.
  - If by reaches height_blks, pulse done and go to IDLE; otherwise go to LOAD.
- busy=1 in every state except IDLE.
- Coefficient buffer reads happen only in DRAIN, so they never overlap dct2d writes.
- Reset mid-frame aborts immediately with no done pulse.

Optional Feature:
- Macro ZIGZAG_EN.
- Defined: ORDER[n] is the MPEG-2 zigzag scan (0,1,8,16,9,2,3,10,17,24,...,63) from an internal 64x6 ROM.
- Undefined: ORDER[n]=n (raster order) and no ROM is built.
- All other timing is identical.

Test Plan:
- Reset with start high -> all outputs 0 and state IDLE; after release, 1x1 frame (base 0, stride 8, pixels 0..63) -> 64 frd with faddr 0..63, baddr 0..63 written one cycle later, one dct_en, 64 outputs, out_last on the 64th, done once.
- 2x2 frame, stride 16, base 0x100 -> block order (0,0),(1,0),(0,1),(1,1); first faddr per block 0x100,0x108,0x180,0x188; second row of block (1,1) starts at 0x198; 256 outputs, 4 out_last, done once.
- Model dct_rdy: low 2 cycles after dct_en, high 70 cycles later -> DRAIN starts only after dct_rdy returns; start pulses during busy are ignored.
- Random out_ready (50%) -> out_data unchanged while stalled; coefficient sequence equals the model in raster order, or in zigzag (caddr 0,1,8,16,9,2,...) with ZIGZAG_EN.
- dct_rdy stuck at 1 -> dct_en high exactly 4 cycles, then err=1 and a done pulse with no outputs; the next start clears err.
- width_blks=0 -> done the next cycle with no frd; reset_n low mid-LOAD -> outputs clear asynchronously and no done pulse.
